// File: rtl/api_extension_mux.sv
// api_extension_mux: routes command transactions to internal registers or extension channels; API_EXT_TIMEOUT_EN adds a ready timeout
module api_extension_mux #(
  parameter int NUM_EXT = 2,
  parameter logic [NUM_EXT*8-1:0] EXT_PREFIXES = {8'hfe, 8'h10},
  parameter int EXT_ADDR_WIDTH = 24,
  parameter int WAIT_CYCLES = 3,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
  input  logic clk,
  input  logic reset,
  input  logic [1:0] command,
  output logic [1:0] status,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic [NUM_EXT-1:0] ext_cs,
  output logic [NUM_EXT-1:0] ext_we,
  output logic [EXT_ADDR_WIDTH-1:0] ext_address,
  output logic [31:0] ext_write_data,
  input  logic [NUM_EXT*32-1:0] ext_read_data,
  input  logic [NUM_EXT-1:0] ext_ready
);
  localparam logic [1:0] BUSY = 2'd0, READY = 2'd1, ERR = 2'd3;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, next_state;
  logic [1:0] cmd_reg;
  logic [7:0] prefix;
  logic [31:0] addr_reg, wdata_reg, off, int_rd, ext_rd, scratch, txn_cnt, err_cnt;
  logic [2:0] wcnt;
  logic [NUM_EXT-1:0] oh;
  logic we_reg, ready_reg, found, internal, dec_err, sel_ready;
  logic start, wait_hit, complete, release_done, tout;
  assign ext_address = addr_reg[EXT_ADDR_WIDTH-1:0];
  assign ext_write_data = wdata_reg;
  assign off = 32'(addr_reg[EXT_ADDR_WIDTH-1:0]);
  assign int_rd = off == 32'h00 ? 32'h6170692d :
                  off == 32'h01 ? 32'h65787420 :
                  off == 32'h02 ? 32'h302e3230 :
                  off == 32'h08 ? 32'(NUM_EXT) :
                  off == 32'h10 ? scratch :
                  off == 32'h20 ? txn_cnt :
                  off == 32'h21 ? err_cnt : 32'h0;
  always_ff @(posedge clk) state <= reset ? IDLE : next_state;
  always_comb
    next_state = state == IDLE ? (cmd_reg != 2'd0 ? WAIT : IDLE) :
                 state == WAIT ? (complete || tout ? DONE : WAIT) :
                 (cmd_reg == 2'd0 ? IDLE : DONE);
  always_comb begin
    start = state == IDLE && cmd_reg != 2'd0;
    wait_hit = state == WAIT && wcnt == 3'(WAIT_CYCLES);
    complete = wait_hit && ready_reg;
    release_done = state == DONE && cmd_reg == 2'd0;
  end
  // In IDLE decode the live address so ready_reg already tracks the target being captured
  always_comb begin
    prefix = state == IDLE ? address[31:24] : addr_reg[31:24];
    internal = prefix == 8'h00;
    found = 1'b0;
    oh = '0;
    sel_ready = 1'b1;
    ext_rd = '0;
    for (int i = NUM_EXT - 1; i >= 0; i--)
      if (!internal && EXT_PREFIXES[8*i +: 8] == prefix) begin
        found = 1'b1;
        oh = '0;
        oh[i] = 1'b1;
        sel_ready = ext_ready[i];
        ext_rd = ext_read_data[32*i +: 32];
      end
    dec_err = !internal && !found;
  end
`ifdef API_EXT_TIMEOUT_EN
  logic [15:0] tcnt;
  always_ff @(posedge clk)
    if (reset || start) tcnt <= '0;
    else if (wait_hit && !ready_reg) tcnt <= tcnt + 16'd1;
  assign tout = wait_hit && !ready_reg && (tcnt + 16'd1) == TIMEOUT_CYCLES;
`else
  assign tout = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_reg <= '0;
      status <= READY;
      read_data <= '0;
      ext_cs <= '0;
      ext_we <= '0;
      addr_reg <= '0;
      wdata_reg <= '0;
      we_reg <= 1'b0;
      ready_reg <= 1'b0;
      wcnt <= 3'(WAIT_CYCLES);
      scratch <= '0;
      txn_cnt <= '0;
      err_cnt <= '0;
    end else begin
      cmd_reg <= command;
      ready_reg <= sel_ready;
      if (start) begin
        addr_reg <= address;
        if (cmd_reg == 2'd3) wdata_reg <= write_data;
        we_reg <= cmd_reg == 2'd3;
        status <= BUSY;
        ext_cs <= oh;
        ext_we <= cmd_reg == 2'd3 ? oh : '0;
        wcnt <= '0;
      end else if (state == WAIT && wcnt != 3'(WAIT_CYCLES)) wcnt <= wcnt + 3'd1;
      if (complete) begin
        read_data <= dec_err ? 32'h0 : internal ? int_rd : ext_rd;
        status <= dec_err ? ERR : READY;
        ext_cs <= '0;
        ext_we <= '0;
      end
      if (tout) begin
        read_data <= 32'hdeadbeef;
        status <= ERR;
        ext_cs <= '0;
        ext_we <= '0;
      end
      if (release_done) status <= READY;
      if (complete && !dec_err) txn_cnt <= txn_cnt + 32'd1;
      if (complete && internal && we_reg && off == 32'h10) scratch <= wdata_reg;
      if (complete && internal && we_reg && off == 32'h21) err_cnt <= '0;
      else if (((complete && dec_err) || tout) && err_cnt != '1) err_cnt <= err_cnt + 32'd1;
    end
  end
endmodule
